// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_rx_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_REL_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous FIFO of decoded key events with count-based full/empty.
// A push is judged against the occupancy before any same-cycle pop.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  ps2_key_evt_t evt_i,
  input  logic         pop_i,
  output ps2_key_evt_t evt_o,
  output logic         valid_o,
  output logic         full_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  ps2_key_evt_t       mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d;
  logic [FIFO_AW-1:0] rd_q, rd_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               wr_en;
  logic               rd_en;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (FIFO_AW + 1)'(DEPTH));
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & valid_o;
  // Head is forced to zero when empty so outputs are clean out of reset.
  assign evt_o   = valid_o ? mem_q[rd_q] : '0;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (wr_en) wr_d = wr_q + 1'b1;
    if (rd_en) rd_d = rd_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= evt_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 pair, deserializes 11-bit
// frames, checks odd parity and stop bit, folds E0/F0 prefixes into flags
// and queues events for a valid/ready consumer.
// Optional partial-frame timeout: define PS2_KBD_RX_TIMEOUT_EN.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  input  logic       key_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;

  ps2_rx_state_t state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic          push;
  logic          tmo_hit;

  ps2_key_evt_t  push_evt;
  ps2_key_evt_t  head_evt;
  logic          fifo_full;

  assign fall = clk_prev_q & ~clk_s2_q;

  // Two-flop synchronizers plus previous-clock register for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_kbd_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_kbd_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

`ifdef PS2_KBD_RX_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q != ST_IDLE) && !fall && (tmo_q == TW'(TIMEOUT));

  // Idle-time counter: cleared by every edge, runs only mid-frame.
  always_comb begin
    tmo_d = tmo_q;
    if (fall || state_q == ST_IDLE || tmo_hit) tmo_d = '0;
    else                                      tmo_d = tmo_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame state machine and prefix decode.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_ok_d  = par_ok_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push      = 1'b0;
    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = (^shreg_q) ^ dat_s2_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dat_s2_q && par_ok_q) begin
            if (shreg_q == PS2_EXT_PREFIX) begin
              ext_d = 1'b1;
            end else if (shreg_q == PS2_REL_PREFIX) begin
              rel_d = 1'b1;
            end else begin
              push  = 1'b1;
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
          end else begin
            perr_d = ~par_ok_q;
            ferr_d = par_ok_q;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end
  end

  assign ovf_d    = push & fifo_full;
  assign push_evt = '{ext: ext_q, rel: rel_q, code: shreg_q};

  // Frame state, shift register, pending flags and one-cycle pulses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_ok_q  <= 1'b0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_ok_q  <= par_ok_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  ps2_evt_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .push_i  (push),
    .evt_i   (push_evt),
    .pop_i   (key_ready),
    .evt_o   (head_evt),
    .valid_o (key_valid),
    .full_o  (fifo_full)
  );

  assign key_code    = head_evt.code;
  assign key_ext     = head_evt.ext;
  assign key_release = head_evt.rel;
  assign err_parity  = perr_q;
  assign err_frame   = ferr_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver that consumes the emulated `ps2_kbd_clk` / `ps2_kbd_data` pair produced by the HPS I/O block. It deserializes 11-bit PS/2 frames, checks odd parity and the stop bit, folds the `E0` (extended) and `F0` (release) prefixes into flags, and queues decoded key events in a small FIFO. The core keyboard-matrix logic pops events from that FIFO over a valid/ready handshake.

## Interface
- `FIFO_AW`, default 2: log2 of the event FIFO depth (default 4 entries).
- `TIMEOUT`, default 20000: idle `clk_sys` cycles before a partial frame is aborted. Used only with `PS2_KBD_RX_TIMEOUT_EN`.

Ports:
- `clk_sys` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_kbd_clk` in 1: PS/2 clock, asynchronous, idles high.
- `ps2_kbd_data` in 1: PS/2 data, asynchronous.
- `key_valid` out 1: FIFO non-empty.
- `key_code` out 8: scan code at the FIFO head.
- `key_ext` out 1: head event was preceded by `E0`.
- `key_release` out 1: head event was preceded by `F0`.
- `key_ready` in 1: consumer pops the head when `key_valid & key_ready`.
- `err_parity` out 1: one-cycle pulse on a parity error.
- `err_frame` out 1: one-cycle pulse on a bad stop bit or a timeout.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Input synchronization.** Each input passes through a 2-flop synchronizer; both synchronizer stages reset to 1. A falling edge is detected when the previous synchronized clock is 1 and the current one is 0. Data is sampled only on that edge.
- **Frame state machine.** `IDLE → DATA → PARITY → STOP → IDLE`.
  - `IDLE`: on a falling edge with data = 0 (start bit), clear `bit_cnt` and go to `DATA`. Data = 1 is ignored; stay in `IDLE`.
  - `DATA`: shift data into `shreg` LSB-first. After the 8th bit (`bit_cnt` = 7), go to `PARITY`.
  - `PARITY`: latch `par_ok = ^shreg ^ data` (1 means odd parity is correct), then go to `STOP`.
  - `STOP`: always return to `IDLE`.
    - data = 1 and `par_ok` = 1: byte is accepted.
    - `par_ok` = 0: pulse `err_parity`.
    - otherwise (stop bit = 0): pulse `err_frame`.
    - Any error clears `ext_pend` and `rel_pend` and discards the byte.
- **Byte decode.**
  - `E0` sets `ext_pend`.
  - `F0` sets `rel_pend`.
  - Any other byte, including `E1`, `AA` and `FA`, pushes `{ext_pend, rel_pend, byte}` into the FIFO and clears both pending flags.
- **FIFO.** Depth 2^`FIFO_AW`, 10-bit entries, occupancy count `FIFO_AW+1` bits wide. Pointers wrap modulo the depth.
  - A push is checked against the count **before** any pop in the same cycle. If the FIFO is full, the event is dropped, `overflow` pulses, and the pending flags are still cleared.
  - Simultaneous push and pop when not full: the count is unchanged.
  - A pop with `key_valid` = 0 is ignored.
- **Output validity.** `key_code`, `key_ext` and `key_release` are valid only while `key_valid` = 1. Otherwise they are don't-care, but they must still be driven.

## Timing
- Reset state: all outputs 0, FIFO empty, state `IDLE`, `bit_cnt` 0, pending flags 0.
- Reset asserted mid-frame aborts the frame immediately. No error pulse is produced.
- The raw falling edge becomes visible to the state machine 3 `clk_sys` cycles later (2 synchronizer cycles plus 1 edge-detect cycle).
- For the stop-bit edge, the push happens in the detect cycle. `key_valid` rises in the next cycle, at most 4 cycles after the raw edge.
- Pop is registered: after a pop, the head advances and `key_valid` updates in the following cycle.
- Back-to-back pops at 1 entry per cycle are supported.
- Error and overflow pulses are exactly 1 cycle wide and are asserted in the cycle after the stop-bit edge is detected.
- The source PS/2 clock period must be at least 8 `clk_sys` cycles.

## Configuration
- `PS2_KBD_RX_TIMEOUT_EN` defined:
  - A counter resets on every detected falling edge and counts while the state is not `IDLE`.
  - When it reaches `TIMEOUT`: state returns to `IDLE`, `err_frame` pulses, and the pending flags clear.
- `PS2_KBD_RX_TIMEOUT_EN` undefined:
  - No counter exists and `TIMEOUT` is unused.
  - A partial frame waits indefinitely for further edges.

## Structure
- Package `ps2_pkg` holds:
  - the state enum `ps2_rx_state_t`;
  - constants `PS2_EXT_PREFIX = 8'hE0` and `PS2_REL_PREFIX = 8'hF0`;
  - the packed struct `ps2_key_evt_t {ext, rel, code[7:0]}`.
- Sub-module `ps2_evt_fifo`: synchronous FIFO of `ps2_key_evt_t` with count-based full/empty, parameterized by `FIFO_AW`.
- The synchronizer, edge detector, frame state machine and decode logic stay in `ps2_kbd_rx`.

## Test plan
1. Frame `1C` with good parity → one event: `code=1C`, `ext=0`, `release=0`; no error pulses.
2. Frames `E0 F0 75` → exactly one event: `code=75`, `ext=1`, `release=1`.
3. Frame `1C` with inverted parity bit → one `err_parity` pulse and no event. A following clean `32` → event `code=32`, `ext=0`.
4. `key_ready` held 0, `FIFO_AW=2`, frames `01 02 03 04 05` → `key_valid=1` with 4 entries and `overflow` pulsing once on `05`. Then `key_ready=1` → `01..04` pop on consecutive cycles.
5. With `PS2_KBD_RX_TIMEOUT_EN`: start bit plus 4 data bits, then clock held high for `TIMEOUT+10` cycles → one `err_frame` pulse. A following frame `29` decodes correctly.
6. `reset_n` pulsed low after the 5th bit of a frame → all outputs 0 and FIFO empty. A following frame `5A` produces event `5A` with no error pulse.
